// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush sequencer with memory-wait watchdog; define PIPE_PERF_EN for stall/flush counters
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             br_mispredict,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_redirect,
    output logic             btb_upd,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, TIMEOUT} state_t;
    state_t cur, nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic mem_stall, to_set;
    assign state = cur;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur <= INIT;
            wait_cnt <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cur <= nxt;
            wait_cnt <= wait_nxt;
            mem_timeout <= mem_timeout | to_set;
        end
    always_comb begin
        nxt = cur;
        wait_nxt = wait_cnt;
        to_set = 1'b0;
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        {if_id_flush, id_ex_flush, pc_redirect, btb_upd} = '0;
        mem_stall = ((cur == RUN && dmem_req) || cur == MEM_WAIT) && !dmem_ready;
        case (cur)
            INIT: begin
                {if_id_flush, id_ex_flush} = 2'b11;
                nxt = RUN;
            end
            TIMEOUT: nxt = TIMEOUT;
            default: begin
                if (mem_stall) begin
                    if (cur == RUN) begin
                        nxt = MEM_WAIT;
                        wait_nxt = WW'(1);
                    end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                        nxt = TIMEOUT;
                        to_set = 1'b1;
                    end else
                        wait_nxt = wait_cnt + WW'(1);
                end else begin
                    nxt = RUN;
                    wait_nxt = '0;
                    // a mispredict squashes the ID instruction, so it masks load_use
                    pc_en = br_mispredict | !load_use;
                    if_id_en = br_mispredict | !load_use;
                    {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                    if_id_flush = br_mispredict;
                    id_ex_flush = br_mispredict | load_use;
                    pc_redirect = br_mispredict;
                    btb_upd = br_mispredict;
                end
            end
        endcase
    end
`ifdef PIPE_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((cur == RUN || cur == MEM_WAIT) && !pc_en && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (btb_upd && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
